// File: rtl/fft_frame_arbiter_if.sv
// ---------------------------------------------------------------------------
// fft_frame_arbiter_if
// Bus bundle between the two AXI-Stream requesters, the FFT core input/config
// channels and the frame arbiter.
//
//   s0_* / s1_*   requester streams (tdata/tvalid/tlast/dir in, tready out)
//   m_*           core s_axis_data channel
//   cfg_*         core s_axis_config channel
//   grant         one-hot owner of the current frame
//   frame_err     1-cycle pulse on a length-mismatched frame close
//
// Modports:
//   master  arbiter side (drives m_*, cfg_*, sN_tready, grant, frame_err)
//   slave   environment side (requesters and core)
// ---------------------------------------------------------------------------
interface fft_frame_arbiter_if #(
    parameter int DW    = 48,
    parameter int CFG_W = 16
);
    logic [DW-1:0]    s0_tdata;
    logic             s0_tvalid;
    logic             s0_tlast;
    logic             s0_dir;
    logic             s0_tready;

    logic [DW-1:0]    s1_tdata;
    logic             s1_tvalid;
    logic             s1_tlast;
    logic             s1_dir;
    logic             s1_tready;

    logic [DW-1:0]    m_tdata;
    logic             m_tvalid;
    logic             m_tlast;
    logic             m_tready;

    logic [CFG_W-1:0] cfg_tdata;
    logic             cfg_tvalid;
    logic             cfg_tready;

    logic [1:0]       grant;
    logic             frame_err;

    modport master (
        input  s0_tdata, s0_tvalid, s0_tlast, s0_dir,
        output s0_tready,
        input  s1_tdata, s1_tvalid, s1_tlast, s1_dir,
        output s1_tready,
        output m_tdata, m_tvalid, m_tlast,
        input  m_tready,
        output cfg_tdata, cfg_tvalid,
        input  cfg_tready,
        output grant, frame_err
    );

    modport slave (
        output s0_tdata, s0_tvalid, s0_tlast, s0_dir,
        input  s0_tready,
        output s1_tdata, s1_tvalid, s1_tlast, s1_dir,
        input  s1_tready,
        input  m_tdata, m_tvalid, m_tlast,
        output m_tready,
        input  cfg_tdata, cfg_tvalid,
        output cfg_tready,
        input  grant, frame_err
    );
endinterface

// File: rtl/fft_frame_arbiter.sv
// ---------------------------------------------------------------------------
// fft_frame_arbiter
// Frame-granular round-robin scheduler sharing one FFT/IFFT core input
// between two AXI-Stream requesters. A direction config word is sent on the
// core config channel before a frame only when the direction changes (or
// none has been configured since reset). Frame length is policed against
// 2**NFFT_LOG2 beats; malformed frames are closed and flagged.
//
// Ports:
//   SYS_CLK    clock
//   SYS_RSTN   asynchronous active-low reset
//   bus        fft_frame_arbiter_if.master bundle (sources, core data,
//              core config, grant, frame_err)
// ---------------------------------------------------------------------------
module fft_frame_arbiter #(
    parameter int DW        = 48,
    parameter int NFFT_LOG2 = 9,
    parameter int CFG_W     = 16
) (
    input  logic                SYS_CLK,
    input  logic                SYS_RSTN,
    fft_frame_arbiter_if.master bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CFG  = 2'd1;
    localparam logic [1:0] ST_XFER = 2'd2;

    localparam logic [NFFT_LOG2-1:0] CNT_LAST = '1;

    logic [1:0]           state_q,   state_d;
    logic                 owner_q,   owner_d;     // 0 = s0, 1 = s1
    logic [1:0]           grant_q,   grant_d;
    logic                 dir_q,     dir_d;       // direction latched at grant
    logic                 rr_q,      rr_d;        // round-robin pointer
    logic                 cfg_mem_q, cfg_mem_d;   // a direction has been configured
    logic                 cfg_dir_q, cfg_dir_d;   // last configured direction
    logic [NFFT_LOG2-1:0] cnt_q,     cnt_d;
    logic                 ferr_q,    ferr_d;

    // ---------------------------------------------------------------
    // Source mux toward the core (zero latency)
    // ---------------------------------------------------------------
    logic          src_tvalid;
    logic          src_tlast;
    logic [DW-1:0] src_tdata;

    assign src_tvalid = owner_q ? bus.s1_tvalid : bus.s0_tvalid;
    assign src_tlast  = owner_q ? bus.s1_tlast  : bus.s0_tlast;
    assign src_tdata  = owner_q ? bus.s1_tdata  : bus.s0_tdata;

    logic in_xfer;
    logic in_cfg;
    logic beat_hs;
    logic cnt_at_last;
    logic closing;

    assign in_xfer     = (state_q == ST_XFER);
    assign in_cfg      = (state_q == ST_CFG);
    assign beat_hs     = in_xfer & src_tvalid & bus.m_tready;
    assign cnt_at_last = (cnt_q == CNT_LAST);
    // A frame closes on the source's tlast or on the N-th beat, whichever first.
    assign closing     = beat_hs & (src_tlast | cnt_at_last);

    assign bus.m_tvalid = in_xfer & src_tvalid;
    assign bus.m_tdata  = in_xfer ? src_tdata : '0;
    // tlast is forced on the N-th beat even if the source omitted it.
    assign bus.m_tlast  = in_xfer & src_tvalid & (src_tlast | cnt_at_last);

    assign bus.s0_tready = in_xfer & ~owner_q & bus.m_tready;
    assign bus.s1_tready = in_xfer &  owner_q & bus.m_tready;

    // ---------------------------------------------------------------
    // Config word: {7'd0, dir, 3'b000, NFFT_LOG2[4:0]}
    // ---------------------------------------------------------------
    logic [CFG_W-1:0] cfg_word;

    always_comb begin
        cfg_word      = '0;
        cfg_word[8]   = dir_q;
        cfg_word[4:0] = NFFT_LOG2[4:0];
    end

    assign bus.cfg_tvalid = in_cfg;
    assign bus.cfg_tdata  = in_cfg ? cfg_word : '0;

    assign bus.grant     = grant_q;
    assign bus.frame_err = ferr_q;

    // ---------------------------------------------------------------
    // Arbitration: the pointer's source wins if it requests, otherwise
    // the other source. Expressed directly as the winner index.
    // ---------------------------------------------------------------
    logic any_req;
    logic winner;
    logic win_dir;
    logic need_cfg;

    assign any_req  = bus.s0_tvalid | bus.s1_tvalid;
    assign winner   = rr_q ? bus.s1_tvalid : ~bus.s0_tvalid;
    assign win_dir  = winner ? bus.s1_dir : bus.s0_dir;
    assign need_cfg = ~cfg_mem_q | (win_dir != cfg_dir_q);

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        grant_d   = grant_q;
        dir_d     = dir_q;
        rr_d      = rr_q;
        cfg_mem_d = cfg_mem_q;
        cfg_dir_d = cfg_dir_q;
        cnt_d     = cnt_q;
        ferr_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    owner_d = winner;
                    dir_d   = win_dir;
                    rr_d    = ~winner;
                    grant_d = winner ? 2'b10 : 2'b01;
                    state_d = need_cfg ? ST_CFG : ST_XFER;
                end
            end

            ST_CFG: begin
                if (bus.cfg_tready) begin
                    cfg_dir_d = dir_q;
                    cfg_mem_d = 1'b1;
                    state_d   = ST_XFER;
                end
            end

            ST_XFER: begin
                if (beat_hs) begin
                    if (closing) begin
                        cnt_d   = '0;
                        grant_d = 2'b00;
                        state_d = ST_IDLE;
                        // Error when exactly one of the two close conditions holds.
                        ferr_d  = src_tlast ^ cnt_at_last;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
                cnt_d   = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------
    always_ff @(posedge SYS_CLK or negedge SYS_RSTN) begin
        if (!SYS_RSTN) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b0;
            grant_q   <= 2'b00;
            dir_q     <= 1'b0;
            rr_q      <= 1'b0;
            cfg_mem_q <= 1'b0;
            cfg_dir_q <= 1'b0;
            cnt_q     <= '0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            grant_q   <= grant_d;
            dir_q     <= dir_d;
            rr_q      <= rr_d;
            cfg_mem_q <= cfg_mem_d;
            cfg_dir_q <= cfg_dir_d;
            cnt_q     <= cnt_d;
            ferr_q    <= ferr_d;
        end
    end

endmodule
